// File: rtl/seg_display_pkg.sv
// Shared types and helpers for the seven-segment display scanner.
// Pin polarity is applied through one helper so every output uses the same rule.
package seg_display_pkg;

  typedef enum logic [0:0] {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

  // Widest vector apply_pol accepts; callers zero-extend in and truncate out.
  localparam int unsigned PolMaxW = 64;

  function automatic logic [PolMaxW-1:0] apply_pol(input logic [PolMaxW-1:0] value,
                                                   input logic               act_low);
    return act_low ? ~value : value;
  endfunction

endpackage

// File: rtl/mux_n.sv
// Combinational N-to-1 selector of W-bit slices packed in a flat vector.
// Out-of-range select values return all zeros.
module mux_n #(
  parameter int unsigned N = 2,
  parameter int unsigned W = 7,
  localparam int unsigned SelW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N*W-1:0]  i_data,
  input  logic [SelW-1:0] i_sel,
  output logic [W-1:0]    o_data
);

  always_comb begin
    o_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (i_sel == SelW'(i)) begin
        o_data = i_data[i*W +: W];
      end
    end
  end

endmodule

// File: rtl/seg_display_scanner.sv
// Time-multiplexed common-anode seven-segment driver: each digit is driven for
// REFRESH_DIV cycles, separated by BLANK_CYCLES of all-dark dead time.
module seg_display_scanner
  import seg_display_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 2,
  parameter int unsigned SEG_W         = 7,
  parameter int unsigned REFRESH_DIV   = 24000,
  parameter int unsigned BLANK_CYCLES  = 240,
  parameter bit          ANODE_ACT_LOW = 1'b1,
  parameter bit          SEG_ACT_LOW   = 1'b1,
  localparam int unsigned IdxW = $clog2(NUM_DIGITS)
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic [NUM_DIGITS*SEG_W-1:0] i_digit_data,
  input  logic [NUM_DIGITS-1:0]       i_digit_en,
  output logic [SEG_W-1:0]            o_seg,
  output logic [NUM_DIGITS-1:0]       o_anode,
  output logic [IdxW-1:0]             o_digit_idx,
  output logic                        o_frame_start
);

  localparam int unsigned CntMaxA = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int unsigned CntMax  = (CntMaxA > 2) ? CntMaxA : 2;
  localparam int unsigned CntW    = $clog2(CntMax);

  localparam logic [CntW-1:0] DriveLast = CntW'(REFRESH_DIV - 1);
  // With no dead time the reset BLANK state exits on the very first edge.
  localparam logic [CntW-1:0] BlankLast = CntW'((BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1);
  localparam logic [IdxW-1:0] LastIdx   = IdxW'(NUM_DIGITS - 1);

  localparam logic [NUM_DIGITS-1:0] AnodeOff = NUM_DIGITS'(apply_pol('0, ANODE_ACT_LOW));
  localparam logic [SEG_W-1:0]      SegOff   = SEG_W'(apply_pol('0, SEG_ACT_LOW));

  if (NUM_DIGITS < 2) begin : g_chk_digits
    $error("seg_display_scanner: NUM_DIGITS must be >= 2");
  end
  if (REFRESH_DIV < 1) begin : g_chk_refresh
    $error("seg_display_scanner: REFRESH_DIV must be >= 1");
  end
  if (SEG_W < 1 || SEG_W > PolMaxW || NUM_DIGITS > PolMaxW) begin : g_chk_width
    $error("seg_display_scanner: SEG_W/NUM_DIGITS out of range");
  end

  scan_state_t           r_state;
  logic [CntW-1:0]       r_cnt;
  logic [IdxW-1:0]       r_idx;
  logic                  r_frame;
  logic [NUM_DIGITS-1:0] r_anode;
  logic [SEG_W-1:0]      r_seg;

  scan_state_t           w_state_next;
  logic [CntW-1:0]       w_cnt_next;
  logic [IdxW-1:0]       w_idx_next;
  logic                  w_enter_drive;
  logic                  w_leave_drive;
  logic [SEG_W-1:0]      w_sel_seg;
  logic                  w_sel_en;
  logic [NUM_DIGITS-1:0] w_onehot;
  logic [SEG_W-1:0]      w_seg_drive;
  logic [NUM_DIGITS-1:0] w_anode_drive;

  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt + 1'b1;
    w_idx_next    = r_idx;
    w_enter_drive = 1'b0;
    w_leave_drive = 1'b0;
    unique case (r_state)
      BLANK: begin
        if (r_cnt == BlankLast) begin
          w_state_next  = DRIVE;
          w_cnt_next    = '0;
          w_enter_drive = 1'b1;
        end
      end
      DRIVE: begin
        if (r_cnt == DriveLast) begin
          w_cnt_next = '0;
          w_idx_next = (r_idx == LastIdx) ? '0 : r_idx + 1'b1;
          if (BLANK_CYCLES == 0) begin
            w_enter_drive = 1'b1;
          end else begin
            w_state_next  = BLANK;
            w_leave_drive = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Select by the upcoming index so DRIVE->DRIVE latches the next digit.
  mux_n #(
    .N (NUM_DIGITS),
    .W (SEG_W)
  ) u_mux (
    .i_data (i_digit_data),
    .i_sel  (w_idx_next),
    .o_data (w_sel_seg)
  );

  always_comb begin
    w_onehot             = '0;
    w_onehot[w_idx_next] = 1'b1;
    w_sel_en             = i_digit_en[w_idx_next];
    w_seg_drive          = w_sel_en ? SEG_W'(apply_pol(PolMaxW'(w_sel_seg), SEG_ACT_LOW)) : SegOff;
    w_anode_drive        = w_sel_en ? NUM_DIGITS'(apply_pol(PolMaxW'(w_onehot), ANODE_ACT_LOW))
                                    : AnodeOff;
  end

  // Pin registers only change at slot boundaries, which is what holds the latch.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= BLANK;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_frame <= 1'b0;
      r_anode <= AnodeOff;
      r_seg   <= SegOff;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_idx   <= w_idx_next;
      r_frame <= w_enter_drive && (w_idx_next == '0);
      if (w_enter_drive) begin
        r_anode <= w_anode_drive;
        r_seg   <= w_seg_drive;
      end else if (w_leave_drive) begin
        r_anode <= AnodeOff;
        r_seg   <= SegOff;
      end
    end
  end

  assign o_seg         = r_seg;
  assign o_anode       = r_anode;
  assign o_digit_idx   = r_idx;
  assign o_frame_start = r_frame;

endmodule

// File: tb/tb_seg_display_scanner.sv
// Scoreboard bench for two scanner builds: 2 digits with dead time, 4 digits without.
// The reference model derives each cycle's pins from the edge count since reset.
module tb_seg_display_scanner;

  typedef struct packed {
    logic [3:0] anode;
    logic [6:0] seg;
    logic [1:0] idx;
    logic       fs;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [13:0] data_a;
  logic [1:0]  en_a;
  logic [27:0] data_b;
  logic [3:0]  en_b;

  logic [6:0] seg_a, seg_b;
  logic [1:0] anode_a;
  logic [3:0] anode_b;
  logic       idx_a;
  logic [1:0] idx_b;
  logic       fs_a, fs_b;

  int total = 0;
  int bad   = 0;

  exp_t qa[$];
  exp_t qb[$];
  bit   started = 1'b0;

  always #5 clk = ~clk;

  seg_display_scanner #(
    .NUM_DIGITS    (2),
    .SEG_W         (7),
    .REFRESH_DIV   (4),
    .BLANK_CYCLES  (2),
    .ANODE_ACT_LOW (1'b1),
    .SEG_ACT_LOW   (1'b1)
  ) dut_a (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_digit_data  (data_a),
    .i_digit_en    (en_a),
    .o_seg         (seg_a),
    .o_anode       (anode_a),
    .o_digit_idx   (idx_a),
    .o_frame_start (fs_a)
  );

  seg_display_scanner #(
    .NUM_DIGITS    (4),
    .SEG_W         (7),
    .REFRESH_DIV   (4),
    .BLANK_CYCLES  (0),
    .ANODE_ACT_LOW (1'b1),
    .SEG_ACT_LOW   (1'b1)
  ) dut_b (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_digit_data  (data_b),
    .i_digit_en    (en_b),
    .o_seg         (seg_b),
    .o_anode       (anode_b),
    .o_digit_idx   (idx_b),
    .o_frame_start (fs_b)
  );

  // Where edge e (1 = first edge with reset low) lands in the scan schedule.
  function automatic void slot_info(input int n, input int r, input int b, input int e,
                                    output bit drive, output int dig, output bit fresh);
    int q, per, k, s;
    drive = 1'b0;
    dig   = 0;
    fresh = 1'b0;
    if (e == 0) return;
    q = (b > 0) ? e - b : e - 1;
    if (q < 0) return;
    per = r + b;
    k   = q % per;
    s   = (q / per) % n;
    if (k < r) begin
      drive = 1'b1;
      dig   = s;
      fresh = (k == 0);
    end else begin
      dig = (s + 1) % n;
    end
  endfunction

  int         ea = 0, eb = 0;
  logic [6:0] lat_a_seg [2];
  logic       lat_a_en  [2];
  logic [6:0] lat_b_seg [4];
  logic       lat_b_en  [4];

  always @(posedge clk) begin
    bit   dr, fr;
    int   dg;
    exp_t x;
    ea = reset ? 0 : ea + 1;
    eb = reset ? 0 : eb + 1;

    slot_info(2, 4, 2, ea, dr, dg, fr);
    if (fr) begin
      lat_a_seg[dg] = data_a[dg*7 +: 7];
      lat_a_en[dg]  = en_a[dg];
    end
    x.anode = (dr && lat_a_en[dg]) ? (4'b0011 & ~(4'b0001 << dg)) : 4'b0011;
    x.seg   = (dr && lat_a_en[dg]) ? ~lat_a_seg[dg] : 7'h7F;
    x.idx   = 2'(dg);
    x.fs    = dr && fr && (dg == 0);
    qa.push_back(x);

    slot_info(4, 4, 0, eb, dr, dg, fr);
    if (fr) begin
      lat_b_seg[dg] = data_b[dg*7 +: 7];
      lat_b_en[dg]  = en_b[dg];
    end
    x.anode = (dr && lat_b_en[dg]) ? (4'b1111 & ~(4'b0001 << dg)) : 4'b1111;
    x.seg   = (dr && lat_b_en[dg]) ? ~lat_b_seg[dg] : 7'h7F;
    x.idx   = 2'(dg);
    x.fs    = dr && fr && (dg == 0);
    qb.push_back(x);

    started = 1'b1;
  end

  task automatic check(input string nm, input exp_t got, input exp_t ex);
    total++;
    if (got !== ex) begin
      bad++;
      $display("FAIL %s t=%0t: got anode=%b seg=%h idx=%0d fs=%b, required anode=%b seg=%h idx=%0d fs=%b",
               nm, $time, got.anode, got.seg, got.idx, got.fs, ex.anode, ex.seg, ex.idx, ex.fs);
    end
  endtask

  always @(negedge clk) begin
    exp_t g;
    if (qa.size() > 0) begin
      g = '{anode: {2'b00, anode_a}, seg: seg_a, idx: {1'b0, idx_a}, fs: fs_a};
      check("dut_a", g, qa.pop_front());
    end else if (started) begin
      total++;
      bad++;
      $display("FAIL dut_a_queue: got empty scoreboard, required one entry");
    end
    if (qb.size() > 0) begin
      g = '{anode: anode_b, seg: seg_b, idx: idx_b, fs: fs_b};
      check("dut_b", g, qb.pop_front());
    end else if (started) begin
      total++;
      bad++;
      $display("FAIL dut_b_queue: got empty scoreboard, required one entry");
    end
  end

  initial begin
    int rst_left;
    reset  = 1'b1;
    data_a = {7'h06, 7'h40};
    en_a   = 2'b11;
    data_b = {7'h4F, 7'h5B, 7'h06, 7'h3F};
    en_b   = 4'hF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    // Two full frames of digits 0/1 = 40/06.
    repeat (24) @(negedge clk);
    // Digit 1 disabled for one frame.
    en_a = 2'b01;
    repeat (12) @(negedge clk);
    // Change digit 0 during its slot (edge 39 is its second cycle).
    repeat (3) @(negedge clk);
    data_a[6:0] = 7'h3F;
    en_a        = 2'b11;
    // Reset sampled on the third cycle of a digit-1 slot (edge 58).
    repeat (18) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    data_a = {7'h06, 7'h40};
    repeat (30) @(negedge clk);

    rst_left = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(7) == 0) data_a = 14'($urandom);
      if ($urandom_range(15) == 0) en_a = 2'($urandom);
      if ($urandom_range(7) == 0) data_b = 28'($urandom);
      if ($urandom_range(15) == 0) en_b = 4'($urandom);
      if (rst_left > 0) begin
        rst_left--;
        reset = (rst_left > 0);
      end else if ($urandom_range(199) == 0) begin
        rst_left = int'($urandom_range(3, 1));
        reset    = 1'b1;
      end
      @(negedge clk);
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
